pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. It drives the

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 95 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side hazard inputs, stage enable/flush controls, statistics.
// The pipeline drives through master; the controller answers through slave.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] if_id_rs;
  logic [REG_ADDR_W-1:0] if_id_rt;
  logic                  id_uses_rt;
  logic                  id_ex_mem_read;
  logic [REG_ADDR_W-1:0] id_ex_rt;
  logic                  ex_branch_taken;
  logic                  dmem_req;
  logic                  dmem_ready;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_write;
  logic                  id_ex_flush;
  logic                  ex_mem_write;
  logic                  mem_wb_flush;
  logic                  mem_wait;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output if_id_rs, if_id_rt, id_uses_rt, id_ex_mem_read, id_ex_rt,
           ex_branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, mem_wait, mem_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, id_uses_rt, id_ex_mem_read, id_ex_rt,
           ex_branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, mem_wait, mem_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage controls are combinational (zero latency);
// a data-memory wait freezes PC..EX/MEM and bubbles MEM/WB until the access completes.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int                    WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO   = '0;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic mem_stall;
  logic load_use;
  logic take_branch;
  logic bubble;

  assign mem_stall = hz.dmem_req & ~hz.dmem_ready;
  assign load_use  = hz.id_ex_mem_read & (hz.id_ex_rt != REG_ZERO) &
                     ((hz.id_ex_rt == hz.if_id_rs) |
                      (hz.id_uses_rt & (hz.id_ex_rt == hz.if_id_rt)));
  // A taken branch squashes the dependent instruction, so it beats load-use.
  assign take_branch = ~mem_stall & hz.ex_branch_taken;
  assign bubble      = ~mem_stall & ~hz.ex_branch_taken & load_use;

  assign hz.pc_write     = reset & ~mem_stall & ~bubble;
  assign hz.if_id_write  = reset & ~mem_stall & ~bubble;
  assign hz.if_id_flush  = reset & take_branch;
  assign hz.id_ex_write  = reset & ~mem_stall;
  assign hz.id_ex_flush  = reset & (take_branch | bubble);
  assign hz.ex_mem_write = reset & ~mem_stall;
  assign hz.mem_wb_flush = reset & mem_stall;
  assign hz.mem_wait     = (state_q == MEM_WAIT);
  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_d    = stall_q;
    flush_d    = flush_q;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d = RUN;
        end else begin
          if (wait_cnt_q != WAIT_LIMIT) wait_cnt_d = wait_cnt_q + 1'b1;
          // The flag latches but the FSM keeps waiting for the memory.
          if (wait_cnt_d == WAIT_LIMIT) timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if ((mem_stall | bubble) && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
    if (take_branch && (flush_q != CNT_MAX))          flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a rule-level model predicts every output each cycle,
// with literal checkpoints for load-use, branch, memory wait, timeout, saturation and reset.
module tb_pipeline_hazard_ctrl;
  localparam int CW  = 5;
  localparam int TO  = 15;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Model state
  bit m_wait;
  int m_wcnt;
  bit m_to;
  int m_stall;
  int m_flush;
  int cur_kind;
  logic last_pcw, last_ifw, last_ifl, last_idf, last_mwf, last_mw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // 1 memory stall, 2 taken branch, 3 load-use bubble, 4 normal flow
  function automatic int kind_now();
    bit ms, lu;
    ms = bus.dmem_req && !bus.dmem_ready;
    lu = bus.id_ex_mem_read && (bus.id_ex_rt != 0) &&
         ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_uses_rt && bus.id_ex_rt == bus.if_id_rt));
    if (ms) return 1;
    if (bus.ex_branch_taken) return 2;
    if (lu) return 3;
    return 4;
  endfunction

  task automatic compare();
    int k;
    bit live;
    k = kind_now();
    cur_kind = k;
    live = (reset === 1'b1);
    chk("pc_write",     bus.pc_write,     live && (k == 2 || k == 4));
    chk("if_id_write",  bus.if_id_write,  live && (k == 2 || k == 4));
    chk("if_id_flush",  bus.if_id_flush,  live && (k == 2));
    chk("id_ex_write",  bus.id_ex_write,  live && (k != 1));
    chk("id_ex_flush",  bus.id_ex_flush,  live && (k == 2 || k == 3));
    chk("ex_mem_write", bus.ex_mem_write, live && (k != 1));
    chk("mem_wb_flush", bus.mem_wb_flush, live && (k == 1));
    chk("mem_wait",     bus.mem_wait,     m_wait);
    chk("mem_timeout",  bus.mem_timeout,  m_to);
    chk("stall_cycles", bus.stall_cycles, m_stall);
    chk("flush_count",  bus.flush_count,  m_flush);
    last_pcw = bus.pc_write;
    last_ifw = bus.if_id_write;
    last_ifl = bus.if_id_flush;
    last_idf = bus.id_ex_flush;
    last_mwf = bus.mem_wb_flush;
    last_mw  = bus.mem_wait;
  endtask

  task automatic model_reset();
    m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic advance();
    if (reset !== 1'b1) begin
      model_reset();
    end else begin
      if (cur_kind == 1 || cur_kind == 3) m_stall = (m_stall < MAX) ? m_stall + 1 : MAX;
      if (cur_kind == 2) m_flush = (m_flush < MAX) ? m_flush + 1 : MAX;
      if (m_wait) begin
        if (bus.dmem_ready) m_wait = 0;
        else begin
          m_wcnt++;
          if (m_wcnt >= TO) m_to = 1;
        end
      end else if (cur_kind == 1) begin
        m_wait = 1;
        m_wcnt = 0;
      end
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] xrt, input logic br,
                       input logic req, input logic rdy);
    bus.if_id_rs = rs;  bus.if_id_rt = rt;  bus.id_uses_rt = urt;
    bus.id_ex_mem_read = mr; bus.id_ex_rt = xrt; bus.ex_branch_taken = br;
    bus.dmem_req = req; bus.dmem_ready = rdy;
  endtask

  // One clock: drive at negedge, check mid-low-phase, advance model at posedge, settle.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mr, input logic [4:0] xrt, input logic br,
                      input logic req, input logic rdy);
    @(negedge clk);
    drive(rs, rt, urt, mr, xrt, br, req, rdy);
    #2 compare();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 compare();
    chk("rst_pc_write", bus.pc_write, 1'b0);
    @(posedge clk); advance(); #1;
    @(negedge clk); reset = 1'b1;
    idle();
    chk("run_pc_write", last_pcw, 1'b1);

    // T1 load-use on rs
    step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("t1_pc_write", last_pcw, 1'b0);
    chk("t1_id_ex_flush", last_idf, 1'b1);
    chk("t1_stall", bus.stall_cycles, 1);
    idle();
    chk("t1_resume", last_pcw, 1'b1);

    // T2 no hazard: rt=0 load, or rt match without rt use; then a real rt hazard
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("t2_no_stall", bus.stall_cycles, 1);
    step(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("t2_rt_stall", bus.stall_cycles, 2);

    // T3 branch overrides load-use
    step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("t3_if_flush", last_ifl, 1'b1);
    chk("t3_pc_write", last_pcw, 1'b1);
    chk("t3_flush_cnt", bus.flush_count, 1);
    chk("t3_stall_cnt", bus.stall_cycles, 2);

    // T4 three-cycle memory wait, with branch and load-use masked during it
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    chk("t4_branch_masked", last_ifl, 1'b0);
    step(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("t4_mem_wb_flush", last_mwf, 1'b1);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("t4_wait_on_ready", last_mw, 1'b1);
    chk("t4_ready_pcw", last_pcw, 1'b1);
    chk("t4_stall", bus.stall_cycles, 5);
    idle();
    chk("t4_back_run", last_mw, 1'b0);

    // T5 ready withheld 20 cycles
    for (int i = 0; i < 20; i++) begin
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      if (i == 14) chk("t5_before_to", bus.mem_timeout, 1'b0);
      if (i == 15) chk("t5_at_to", bus.mem_timeout, 1'b1);
    end
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle();
    chk("t5_sticky", bus.mem_timeout, 1'b1);
    chk("t5_stall", bus.stall_cycles, 25);

    // Saturation of the stall counter
    for (int i = 0; i < 10; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("sat_stall", bus.stall_cycles, MAX);

    // T6 reset asserted while in MEM_WAIT
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2 compare();
    chk("t6_pre_wait", last_mw, 1'b1);
    reset = 1'b0;
    #1 model_reset();
    compare();
    chk("t6_wait_clr", bus.mem_wait, 1'b0);
    chk("t6_writes_off", bus.id_ex_write, 1'b0);
    chk("t6_stall_clr", bus.stall_cycles, 0);
    chk("t6_to_clr", bus.mem_timeout, 1'b0);
    @(posedge clk); advance(); #1;
    @(negedge clk); reset = 1'b1;
    idle();
    chk("t6_run", last_mw, 1'b0);
    chk("t6_run_pcw", last_pcw, 1'b1);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("t6_flush_restart", bus.flush_count, 1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
